pipe_reg: RTL and testbench
===========================

PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 4, sets the data width in bits; legal range is 1 or more.
REQ-002 Parameter DEPTH, default 2, sets the number of register stages; legal range is 1 or more.
REQ-003 Parameter RESET_VAL, default all-zero, WIDTH bits: the value every data register takes on reset.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of all stage valid bits.
REQ-007 in_valid  input  1  upstream data is valid this cycle.
REQ-008 in_ready  output  1  the block accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data is valid this cycle.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  WIDTH  payload of the last stage.
REQ-013 count  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

Function
REQ-014 Each stage k (0..DEPTH-1) shall hold one valid bit v[k] and one data word d[k]; stage 0 faces the input and stage DEPTH-1 drives out_valid and out_data.
REQ-015 The stage ready signal shall be rdy[k] = !v[k] || rdy[k+1], with rdy[DEPTH] = out_ready (bubble-collapsing); in_ready = rdy[0] && !flush.
REQ-016 On a clock edge with rdy[k] high, stage k shall load v[k] from the upstream valid; it shall load d[k] from the upstream data only when the upstream valid is also high, and otherwise hold d[k].
REQ-017 A transfer occurs on each side only when valid && ready are both high at the edge; data shall never be duplicated or dropped except by flush or reset.
REQ-018 Latency with no stall shall be exactly DEPTH cycles from the input handshake to out_valid; sustained throughput shall be one word per cycle.
REQ-019 While out_ready is low and all stages are valid, in_ready shall be low and every v[k] and d[k] shall hold.
REQ-020 Empty stages shall collapse: a word accepted while downstream stages are empty advances one stage per cycle even if out_ready is low, until it reaches the last empty stage.
REQ-021 Simultaneous input and output handshakes with all stages full shall keep count unchanged and shift every word one stage.
REQ-022 While flush is high, out_valid and in_ready shall be 0; at the next edge all v[k] shall clear to 0, and d[k] is a don't-care for checking.
REQ-023 Flush shall take priority over any concurrent in_valid and out_ready.
REQ-024 count shall equal the popcount of v[] and shall be registered-consistent with v[] in the same cycle, never exceeding DEPTH.
REQ-025 out_valid shall equal v[DEPTH-1] && !flush, and out_data shall equal d[DEPTH-1].

Reset
REQ-026 On reset_n low, asynchronously and regardless of clk: all v[k] = 0 and all d[k] = RESET_VAL.
REQ-027 The reset values on the outputs shall be out_valid = 0, out_data = RESET_VAL, count = 0, and in_ready = 1 (unless flush is high).
REQ-028 Reset deassertion mid-traffic shall resume from the empty state; no pre-reset word shall emerge.

Structure
REQ-029 Package pipe_reg_pkg shall hold the default WIDTH/DEPTH constants and a parametrisable stage typedef (valid bit plus data word).
REQ-030 The single sub-module pipe_stage shall implement one valid/data stage with its ready equation.
REQ-031 pipe_reg shall instantiate DEPTH copies of pipe_stage in a generate loop and compute count.
REQ-032 The in_ready to out_ready path is combinational by design; no skid buffer is included.

Verification (WIDTH=4, DEPTH=2, RESET_VAL=4'h0)
REQ-033 Assert reset_n=0 mid-run with both stages full -> out_valid=0, out_data=4'h0 and count=0 immediately, without waiting for a clk edge.
REQ-034 Drive in_valid=1 with 4'h3, 4'h7, 4'hA on consecutive cycles, out_ready=1 -> 4'h3, 4'h7, 4'hA appear on out_data on cycles 2, 3 and 4 after the first handshake.
REQ-035 Hold out_ready=0 and send 4'h5 then 4'h9 -> count=2, in_ready=0, out_data=4'h5 held; raise out_ready -> 4'h5 then 4'h9 are delivered and count returns to 0.
REQ-036 Send one word 4'hC into an empty pipe with out_ready=0 -> the word collapses to the last stage after 2 edges, count=1, in_ready stays 1.
REQ-037 Full pipe plus flush=1 with in_valid=1 carrying 4'hF -> out_valid=0 and in_ready=0 during the flush cycle; count=0 after the edge, and 4'hF is never output.
REQ-038 Full pipe with in_valid=1 and out_ready=1 held for 10 cycles -> one word out per cycle, in order, with count constant at 2.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared defaults, stage record type and count-width helper for pipe_reg
package pipe_reg_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;

  // One stage record at the default width; pipe_stage declares the same shape at its own WIDTH.
  typedef struct packed {
    logic                 v;
    logic [DEF_WIDTH-1:0] d;
  } stage_def_t;

  // Bits needed to hold a stage count in the range 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/data register stage with bubble-collapsing ready
module pipe_stage
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_ready_i,
  output logic             rdy_o,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } stage_t;

  stage_t s_q, s_d;

  // An empty stage can always take a word; a full one only if it can pass its own word on.
  assign rdy_o = !s_q.v || dn_ready_i;
  assign v_o   = s_q.v;
  assign d_o   = s_q.d;

  // Next state: flush empties the stage, otherwise load when ready; data only moves with a valid word.
  always_comb begin
    s_d.v = flush ? 1'b0 : (rdy_o ? up_valid_i : s_q.v);
    s_d.d = (rdy_o && up_valid_i && !flush) ? up_data_i : s_q.d;
  end

  // Stage register with asynchronous reset to empty / RESET_VAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_q <= '{v: 1'b0, d: RESET_VAL};
    else          s_q <= s_d;
  end

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready register pipeline with flush and occupancy count
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH:0]   rdy;
  logic [WIDTH-1:0] d [DEPTH];

  // Ready ripples combinationally from the output back to the input; no skid buffer.
  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0] && !flush;
  assign out_valid  = v[DEPTH-1] && !flush;
  assign out_data   = d[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_tail
      assign up_v = v[k-1];
      assign up_d = d[k-1];
    end
    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .up_valid_i (up_v),
      .up_data_i  (up_d),
      .dn_ready_i (rdy[k+1]),
      .rdy_o      (rdy[k]),
      .v_o        (v[k]),
      .d_o        (d[k])
    );
  end

  // Occupancy is the popcount of the stage valid bits.
  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) count = count + CW'(v[k]);
  end

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed scoreboard bench for pipe_reg (WIDTH=4, DEPTH=2)
module tb_pipe_reg;

  logic       clk = 1'b0;
  logic       reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_data, out_data;
  logic [1:0] count;

  int vectors = 0;
  int errs    = 0;
  logic [3:0] exp_q [$];

  pipe_reg #(.WIDTH(4), .DEPTH(2), .RESET_VAL(4'h0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Record accepted words at the negedge, then move to just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    if (reset_n && in_valid && in_ready) exp_q.push_back(in_data);
    if (flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", {4'h0, out_data}, 8'hEE);
      else chk("scoreboard_data", {4'h0, out_data}, {4'h0, exp_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {7'h0, out_valid}, 8'h0);
    chk("rst_out_data", {4'h0, out_data}, 8'h0);
    chk("rst_count", {6'h0, count}, 8'h0);
    chk("rst_in_ready", {7'h0, in_ready}, 8'h1);
    reset_n = 1'b1;
    cyc();
    // Streaming latency: 3,7,A on cycles 2,3,4 after the first handshake.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'h3;
    cyc();
    in_data = 4'h7; #1;
    chk("lat_c1_valid", {7'h0, out_valid}, 8'h0);
    cyc();
    in_data = 4'hA; #1;
    chk("lat_c2_valid", {7'h0, out_valid}, 8'h1);
    chk("lat_c2_data", {4'h0, out_data}, 8'h3);
    cyc();
    in_valid = 1'b0; #1;
    chk("lat_c3_data", {4'h0, out_data}, 8'h7);
    cyc();
    chk("lat_c4_data", {4'h0, out_data}, 8'hA);
    cyc();
    chk("lat_c5_valid", {7'h0, out_valid}, 8'h0);
    chk("lat_c5_count", {6'h0, count}, 8'h0);
    // Stall: 5 and 9 held while out_ready is low; a third word must not enter.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h5;
    cyc();
    in_data = 4'h9;
    cyc();
    in_data = 4'hE; #1;
    chk("stall_count", {6'h0, count}, 8'h2);
    chk("stall_in_ready", {7'h0, in_ready}, 8'h0);
    chk("stall_out_data", {4'h0, out_data}, 8'h5);
    cyc();
    chk("stall_hold_data", {4'h0, out_data}, 8'h5);
    chk("stall_hold_count", {6'h0, count}, 8'h2);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("drain_data", {4'h0, out_data}, 8'h9);
    chk("drain_count", {6'h0, count}, 8'h1);
    cyc();
    chk("drain_empty", {6'h0, count}, 8'h0);
    // Collapse: a lone word reaches the last stage with out_ready low.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hC;
    cyc();
    in_valid = 1'b0; #1;
    chk("collapse_e1_valid", {7'h0, out_valid}, 8'h0);
    cyc();
    chk("collapse_count", {6'h0, count}, 8'h1);
    chk("collapse_valid", {7'h0, out_valid}, 8'h1);
    chk("collapse_data", {4'h0, out_data}, 8'hC);
    chk("collapse_in_ready", {7'h0, in_ready}, 8'h1);
    out_ready = 1'b1;
    cyc();
    chk("collapse_drained", {6'h0, count}, 8'h0);
    // Flush a full pipe while F is offered and downstream is ready.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h1;
    cyc();
    in_data = 4'h2;
    cyc();
    flush = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1; #1;
    chk("flush_out_valid", {7'h0, out_valid}, 8'h0);
    chk("flush_in_ready", {7'h0, in_ready}, 8'h0);
    cyc();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_count", {6'h0, count}, 8'h0);
    repeat (3) begin
      chk("flush_no_output", {7'h0, out_valid}, 8'h0);
      cyc();
    end
    // Full-throughput: 10 cycles of simultaneous in/out handshakes on a full pipe.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h0;
    cyc();
    in_data = 4'h1;
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 4'(i + 2); #1;
      chk("thru_count", {6'h0, count}, 8'h2);
      chk("thru_data", {4'h0, out_data}, 8'(i));
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("thru_drained", {6'h0, count}, 8'h0);
    // Asynchronous reset mid-cycle with both stages full.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h6;
    cyc();
    in_data = 4'h8;
    cyc();
    in_valid = 1'b0; #2;
    chk("pre_reset_count", {6'h0, count}, 8'h2);
    reset_n = 1'b0; #1;
    exp_q.delete();
    chk("async_rst_valid", {7'h0, out_valid}, 8'h0);
    chk("async_rst_data", {4'h0, out_data}, 8'h0);
    chk("async_rst_count", {6'h0, count}, 8'h0);
    @(posedge clk); #1;
    reset_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      chk("post_reset_empty", {7'h0, out_valid}, 8'h0);
      cyc();
    end
    chk("queue_empty", 8'(exp_q.size()), 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
